// File: rtl/snake_move_scheduler.sv
// Two-player snake game controller: decodes WASD / arrow keycodes into pending
// directions, issues synchronized step pulses, and detects wall/head collisions.
module snake_move_scheduler #(
    parameter int unsigned STEP_FRAMES = 4,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 639,
    parameter int unsigned Y_MIN       = 0,
    parameter int unsigned Y_MAX       = 479,
    parameter int unsigned HEAD_SIZE   = 12
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] keycode,
    input  logic [9:0]  head1_x,
    input  logic [9:0]  head1_y,
    input  logic [9:0]  head2_x,
    input  logic [9:0]  head2_y,
    output logic [1:0]  dir1,
    output logic [1:0]  dir2,
    output logic        step1,
    output logic        step2,
    output logic [1:0]  game_state,
    output logic [1:0]  crash
);

    localparam int unsigned CW   = 10;
    localparam int unsigned EW   = 11;
    localparam int unsigned CNTW = 8;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      dir1_q, dir1_d, dir2_q, dir2_d;
    logic [1:0]      pend1_q, pend1_d, pend2_q, pend2_d;
    logic            step1_q, step1_d, step2_q, step2_d;
    logic [1:0]      crash_q, crash_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    // Returns {valid, dir} for one 8-bit key slot.
    function automatic logic [2:0] dec_p1(input logic [7:0] k);
        case (k)
            8'h1A:   dec_p1 = {1'b1, DIR_UP};
            8'h16:   dec_p1 = {1'b1, DIR_DOWN};
            8'h04:   dec_p1 = {1'b1, DIR_LEFT};
            8'h07:   dec_p1 = {1'b1, DIR_RIGHT};
            default: dec_p1 = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] dec_p2(input logic [7:0] k);
        case (k)
            8'h52:   dec_p2 = {1'b1, DIR_UP};
            8'h51:   dec_p2 = {1'b1, DIR_DOWN};
            8'h50:   dec_p2 = {1'b1, DIR_LEFT};
            8'h4F:   dec_p2 = {1'b1, DIR_RIGHT};
            default: dec_p2 = 3'b000;
        endcase
    endfunction

    // Widened to 11 bits so x+HEAD_SIZE never wraps near the right/bottom edge.
    function automatic logic wall_hit(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [EW-1:0] xe, ye;
        xe = EW'(x);
        ye = EW'(y);
        wall_hit = (xe + EW'(HEAD_SIZE) >= EW'(X_MAX)) || (xe < EW'(X_MIN + HEAD_SIZE)) ||
                   (ye + EW'(HEAD_SIZE) >= EW'(Y_MAX)) || (ye < EW'(Y_MIN + HEAD_SIZE));
    endfunction

    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        abs_diff = (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [2:0] req1_c, req2_c;
    logic [2:0] r1s0, r1s1, r2s0, r2s1;
    logic       h2h_c, hit1_c, hit2_c;

    // Slot1 overrides slot0 when both name the same player.
    always_comb begin
        r1s0   = dec_p1(keycode[7:0]);
        r1s1   = dec_p1(keycode[15:8]);
        r2s0   = dec_p2(keycode[7:0]);
        r2s1   = dec_p2(keycode[15:8]);
        req1_c = r1s1[2] ? r1s1 : r1s0;
        req2_c = r2s1[2] ? r2s1 : r2s0;
    end

    always_comb begin
        h2h_c  = (abs_diff(head1_x, head2_x) < CW'(2 * HEAD_SIZE)) &&
                 (abs_diff(head1_y, head2_y) < CW'(2 * HEAD_SIZE));
        hit1_c = wall_hit(head1_x, head1_y) || h2h_c;
        hit2_c = wall_hit(head2_x, head2_y) || h2h_c;
    end

    always_comb begin
        state_d = state_q;
        dir1_d  = dir1_q;
        dir2_d  = dir2_q;
        pend1_d = pend1_q;
        pend2_d = pend2_q;
        step1_d = 1'b0;
        step2_d = 1'b0;
        crash_d = crash_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    crash_d = 2'b00;
                    cnt_d   = '0;
                    dir1_d  = DIR_RIGHT;
                    dir2_d  = DIR_LEFT;
                    pend1_d = DIR_RIGHT;
                    pend2_d = DIR_LEFT;
                end
            end
            ST_RUN: begin
                // Reversal check compares against the committed, not pending, direction.
                if (req1_c[2] && (req1_c[1:0] != (dir1_q ^ 2'b01))) pend1_d = req1_c[1:0];
                if (req2_c[2] && (req2_c[1:0] != (dir2_q ^ 2'b01))) pend2_d = req2_c[1:0];
                if (hit1_c || hit2_c) begin
                    state_d = ST_OVER;
                    crash_d = crash_q | {hit2_c, hit1_c};
                end else if (!start) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNTW'(STEP_FRAMES - 1)) begin
                    cnt_d   = '0;
                    step1_d = 1'b1;
                    step2_d = 1'b1;
                    dir1_d  = pend1_q;
                    dir2_d  = pend2_q;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_OVER: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            dir1_q  <= DIR_RIGHT;
            dir2_q  <= DIR_LEFT;
            pend1_q <= DIR_RIGHT;
            pend2_q <= DIR_LEFT;
            step1_q <= 1'b0;
            step2_q <= 1'b0;
            crash_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir1_q  <= dir1_d;
            dir2_q  <= dir2_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            step1_q <= step1_d;
            step2_q <= step2_d;
            crash_q <= crash_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dir1       = dir1_q;
    assign dir2       = dir2_q;
    assign step1      = step1_q;
    assign step2      = step2_q;
    assign game_state = state_q;
    assign crash      = crash_q;

endmodule
